// File: rtl/progmem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The optional checksum stage is enabled with the LOADER_CHECKSUM_EN macro.
package progmem_loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;

   localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      StIdle,
      StALo,
      StAHi,
      StCLo,
      StCHi,
      StDLo,
      StDHi,
      StCsum
   } state_e;

endpackage

// File: rtl/progmem_loader_timeout.sv
// Inter-byte idle counter: clears on request, counts while enabled and
// saturates at TIMEOUT, flagging expiry.
module progmem_loader_timeout #(
   parameter int unsigned TIMEOUT = 2500000
) (
   input  logic i_clock,
   input  logic i_locked,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;
   logic          w_expire;

   assign w_expire = (r_count == CW'(TIMEOUT));
   assign o_expire = w_expire;

   always_ff @(posedge i_clock or negedge i_locked) begin
      if (!i_locked) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_expire) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/progmem_loader.sv
// Boot-time program loader: assembles framed serial bytes into 16-bit words and
// writes them to program memory. Optional checksum byte via LOADER_CHECKSUM_EN.
module progmem_loader
   import progmem_loader_pkg::*;
#(
   parameter int unsigned       TIMEOUT = 2500000,
   parameter bit                AUTORUN = 1'b1,
   parameter logic [BYTE_W-1:0] SYNC    = SYNC_DEFAULT
) (
   input  logic              i_clock,
   input  logic              i_locked,
   input  logic              i_rx_valid,
   input  logic [BYTE_W-1:0] i_rx_data,
   output logic [WORD_W-1:0] o_pm_address,
   output logic [WORD_W-1:0] o_pm_data,
   output logic              o_pm_we,
   output logic              o_core_run,
   output logic              o_busy,
   output logic              o_error
);

   state_e              r_state;
   logic [WORD_W-1:0]   r_addr;
   logic [WORD_W-1:0]   r_cnt;
   logic [BYTE_W-1:0]   r_lo;
   logic [WORD_W-1:0]   r_pm_address;
   logic [WORD_W-1:0]   r_pm_data;
   logic                r_pm_we;
   logic                r_core_run;
   logic                r_busy;
   logic                r_error;
   logic                r_fin;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]   r_sum;
`endif

   logic                w_expire;
   logic                w_abort;
   logic                w_tmo_clear;

   assign w_tmo_clear = i_rx_valid || !r_busy;
   // The finish-pending cycle must not be mistaken for an idle gap.
   assign w_abort     = r_busy && w_expire && !r_fin;

   progmem_loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clock  (i_clock),
      .i_locked (i_locked),
      .i_clear  (w_tmo_clear),
      .i_enable (r_busy),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clock or negedge i_locked) begin
      if (!i_locked) begin
         r_state      <= StIdle;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_lo         <= '0;
         r_pm_address <= '0;
         r_pm_data    <= '0;
         r_pm_we      <= 1'b0;
         r_core_run   <= AUTORUN;
         r_busy       <= 1'b0;
         r_error      <= 1'b0;
         r_fin        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_sum        <= '0;
`endif
      end else begin
         r_pm_we <= 1'b0;
         if (w_abort) begin
            // Partial image is never released to the core.
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
            r_core_run <= 1'b0;
         end else begin
            if (r_fin) begin
               r_fin      <= 1'b0;
               r_busy     <= 1'b0;
               r_core_run <= 1'b1;
            end
            if (i_rx_valid) begin
               unique case (r_state)
                  StIdle: begin
                     if (i_rx_data == SYNC) begin
                        r_busy     <= 1'b1;
                        r_core_run <= 1'b0;
                        r_error    <= 1'b0;
                        r_fin      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum      <= '0;
`endif
                        r_state    <= StALo;
                     end
                  end
                  StALo: begin
                     r_addr[7:0] <= i_rx_data;
                     r_state     <= StAHi;
                  end
                  StAHi: begin
                     r_addr[15:8] <= i_rx_data;
                     r_state      <= StCLo;
                  end
                  StCLo: begin
                     r_cnt[7:0] <= i_rx_data;
                     r_state    <= StCHi;
                  end
                  StCHi: begin
                     r_cnt[15:8] <= i_rx_data;
                     if ({i_rx_data, r_cnt[7:0]} == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= StCsum;
`else
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_core_run <= 1'b1;
`endif
                     end else begin
                        r_state <= StDLo;
                     end
                  end
                  StDLo: begin
                     r_lo    <= i_rx_data;
`ifdef LOADER_CHECKSUM_EN
                     r_sum   <= r_sum + i_rx_data;
`endif
                     r_state <= StDHi;
                  end
                  StDHi: begin
                     r_pm_data    <= {i_rx_data, r_lo};
                     r_pm_address <= r_addr;
                     r_pm_we      <= 1'b1;
                     r_addr       <= r_addr + 16'd1;
                     r_cnt        <= r_cnt - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                     r_sum        <= r_sum + i_rx_data;
`endif
                     if (r_cnt == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= StCsum;
`else
                        // Release the core one cycle after the final strobe.
                        r_state <= StIdle;
                        r_fin   <= 1'b1;
`endif
                     end else begin
                        r_state <= StDLo;
                     end
                  end
`ifdef LOADER_CHECKSUM_EN
                  StCsum: begin
                     r_state    <= StIdle;
                     r_busy     <= 1'b0;
                     r_core_run <= (i_rx_data == r_sum);
                     r_error    <= (i_rx_data != r_sum);
                  end
`endif
                  default: begin
                     r_state <= StIdle;
                  end
               endcase
            end
         end
      end
   end

   assign o_pm_address = r_pm_address;
   assign o_pm_data    = r_pm_data;
   assign o_pm_we      = r_pm_we;
   assign o_core_run   = r_core_run;
   assign o_busy       = r_busy;
   assign o_error      = r_error;

endmodule

// File: tb/tb_progmem_loader.sv
// Scoreboard bench for progmem_loader; expected writes are queued by the driver
// and matched by a monitor. Follows LOADER_CHECKSUM_EN when defined.
module tb_progmem_loader;

   localparam int unsigned TMO = 20;

   logic        clk = 1'b0;
   logic        locked = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic [15:0] pm_address;
   logic [15:0] pm_data;
   logic        pm_we;
   logic        core_run;
   logic        busy;
   logic        error;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   progmem_loader #(
      .TIMEOUT (TMO),
      .AUTORUN (1'b1),
      .SYNC    (8'hA5)
   ) dut (
      .i_clock      (clk),
      .i_locked     (locked),
      .i_rx_valid   (rx_valid),
      .i_rx_data    (rx_data),
      .o_pm_address (pm_address),
      .o_pm_data    (pm_data),
      .o_pm_we      (pm_we),
      .o_core_run   (core_run),
      .o_busy       (busy),
      .o_error      (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Write monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (locked && pm_we) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required none",
                     pm_address, pm_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if ({pm_address, pm_data} !== e)
               begin
                  n_errors++;
                  $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                           pm_address, pm_data, e[31:16], e[15:0]);
               end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_checks++;
      if (got !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_sum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
      send(b);
`else
      if (b == 8'h00) rx_data = 8'h00;
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   initial begin
      // Reset
      idle(3);
      chk("rst_core_run", 32'(core_run), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pm_we", 32'(pm_we), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      locked = 1'b1;
      idle(2);

      // Stray bytes are ignored
      send(8'h00);
      send(8'h55);
      idle(1);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_core_run", 32'(core_run), 32'd1);

      // Two-word frame
      send(8'hA5);
      chk("f1_busy_on_sync", 32'(busy), 32'd1);
      chk("f1_core_stopped", 32'(core_run), 32'd0);
      send(8'h00); send(8'h01); send(8'h02); send(8'h00);
      expect_wr(16'h0100, 16'h940C);
      expect_wr(16'h0101, 16'h1234);
      send(8'h0C); send(8'h94);
      chk("f1_core_mid", 32'(core_run), 32'd0);
      send(8'h34); send(8'h12);
`ifdef LOADER_CHECKSUM_EN
      send(8'hE6);
      chk("f1_busy_done", 32'(busy), 32'd0);
`else
      chk("f1_busy_at_last_we", 32'(busy), 32'd1);
      idle(1);
      chk("f1_busy_done", 32'(busy), 32'd0);
`endif
      chk("f1_core_run", 32'(core_run), 32'd1);
      chk("f1_error", 32'(error), 32'd0);
      idle(2);

      // Address wrap
      send(8'hA5); send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
      expect_wr(16'hFFFF, 16'h2211);
      expect_wr(16'h0000, 16'h4433);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send_sum(8'hAA);
      idle(3);
      chk("wrap_core_run", 32'(core_run), 32'd1);
      chk("wrap_error", 32'(error), 32'd0);

      // Zero-length frame
      send(8'hA5); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
      send_sum(8'h00);
      idle(3);
      chk("cnt0_core_run", 32'(core_run), 32'd1);
      chk("cnt0_busy", 32'(busy), 32'd0);
      chk("cnt0_error", 32'(error), 32'd0);

      // Timeout after a half word
      send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h00); send(8'h0C);
      idle(TMO - 5);
      chk("tmo_still_busy", 32'(busy), 32'd1);
      idle(15);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_error", 32'(error), 32'd1);
      chk("tmo_core_run", 32'(core_run), 32'd0);

      // Next good frame clears error
      send(8'hA5);
      chk("recover_error_clr", 32'(error), 32'd0);
      send(8'h20); send(8'h00); send(8'h01); send(8'h00);
      expect_wr(16'h0020, 16'h5678);
      send(8'h78); send(8'h56);
      send_sum(8'hCE);
      idle(3);
      chk("recover_core_run", 32'(core_run), 32'd1);
      chk("recover_error", 32'(error), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum: writes still occur, core held
      send(8'hA5); send(8'h00); send(8'h01); send(8'h02); send(8'h00);
      expect_wr(16'h0100, 16'h940C);
      expect_wr(16'h0101, 16'h1234);
      send(8'h0C); send(8'h94); send(8'h34); send(8'h12);
      send(8'hE5);
      idle(2);
      chk("badsum_error", 32'(error), 32'd1);
      chk("badsum_core_run", 32'(core_run), 32'd0);
      chk("badsum_busy", 32'(busy), 32'd0);
`endif

      // Reset mid-frame, after one word has been written
      send(8'hA5); send(8'h00); send(8'h03); send(8'h05); send(8'h00);
      expect_wr(16'h0300, 16'h0201);
      send(8'h01); send(8'h02); send(8'h03);
      #1 locked = 1'b0;
      #1;
      chk("mid_rst_core_run", 32'(core_run), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_error", 32'(error), 32'd0);
      chk("mid_rst_pm_we", 32'(pm_we), 32'd0);
      chk("mid_rst_addr", 32'(pm_address), 32'd0);
      chk("mid_rst_data", 32'(pm_data), 32'd0);
      idle(2);
      locked = 1'b1;
      idle(1);

      // Loader accepts a fresh frame after reset
      send(8'hA5); send(8'h40); send(8'h00); send(8'h01); send(8'h00);
      expect_wr(16'h0040, 16'hBBAA);
      send(8'hAA); send(8'hBB);
      send_sum(8'h65);
      idle(3);
      chk("post_rst_core_run", 32'(core_run), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("writes_left", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
